// File: rtl/lvds_rx_pkg.sv
// Shared constants and types for the LVDS receive deframer.
// The word type carries the packed data plus its end-of-frame marker.
package lvds_rx_pkg;

    localparam int LANE_BITS           = 4;
    localparam int BYTES_PER_WORD      = 4;
    localparam int WORD_W              = 32;
    localparam int DEFAULT_FRAME_BYTES = 896;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_t;

endpackage

// File: rtl/lvds_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// A write at full is accepted only when a read happens in the same cycle.
module lvds_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Head entry is masked while empty so the outputs read 0 straight out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lvds_rx_deframer.sv
// Rebuilds bytes from the 2-lane nibble stream, packs them into framed 32-bit words
// and streams them out; LVDS_RX_PATTERN_CHK_EN adds an incrementing-pattern checker.
module lvds_rx_deframer
    import lvds_rx_pkg::*;
#(
    parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data0,
    input  logic              data1,
    input  logic              flag,
    input  logic              clr_stats,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  sync_err_cnt,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  pat_err_cnt
);

    localparam int POS_W  = $clog2(FRAME_BYTES);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam int ACC_W  = (BYTES_PER_WORD - 1) * 8;

    logic [1:0]           bit_cnt;
    logic [LANE_BITS-2:0] sr0;
    logic [LANE_BITS-2:0] sr1;
    logic [7:0]           byte_q;
    logic                 byte_vld;
    logic                 sync_err;
    logic [POS_W-1:0]     pos;
    logic [ACC_W-1:0]     acc;
    word_t                wr_word;
    logic                 wr_vld;
    word_t                rd_word;
    logic                 full;
    logic                 empty;
    logic                 rd_fire;
    logic                 drop;
    logic                 wr_ok;

    assign sync_err = ~flag & (bit_cnt != 2'd0);

    // Only the three older bits of each nibble are held; the newest bit is taken live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            sr0      <= '0;
            sr1      <= '0;
            byte_q   <= '0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= flag & (bit_cnt == 2'd3);
            if (flag) begin
                bit_cnt <= bit_cnt + 2'd1;
                sr0     <= {data0, sr0[LANE_BITS-2:1]};
                sr1     <= {data1, sr1[LANE_BITS-2:1]};
                if (bit_cnt == 2'd3) begin
                    byte_q <= {data1, sr1, data0, sr0};
                end
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            acc     <= '0;
            wr_word <= '0;
            wr_vld  <= 1'b0;
        end else begin
            wr_vld <= 1'b0;
            if (sync_err) begin
                pos <= '0;
                acc <= '0;
            end else if (byte_vld) begin
                if (pos[LANE_W-1:0] == LANE_W'(BYTES_PER_WORD - 1)) begin
                    wr_vld       <= 1'b1;
                    wr_word.data <= {byte_q, acc};
                    wr_word.last <= (pos == POS_W'(FRAME_BYTES - 1));
                end else begin
                    acc[{pos[LANE_W-1:0], 3'b000} +: 8] <= byte_q;
                end
                pos <= (pos == POS_W'(FRAME_BYTES - 1)) ? '0 : pos + POS_W'(1);
            end
        end
    end

    assign rd_fire = m_tready & ~empty;
    assign drop    = wr_vld & full & ~rd_fire;
    assign wr_ok   = wr_vld & ~drop;

    lvds_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_vld),
        .wr_data (wr_word),
        .rd_en   (m_tready),
        .rd_data (rd_word),
        .full    (full),
        .empty   (empty)
    );

    assign m_tvalid = ~empty;
    assign m_tdata  = rd_word.data;
    assign m_tlast  = rd_word.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            sync_err_cnt <= '0;
            ovf_sticky   <= 1'b0;
        end else if (clr_stats) begin
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            sync_err_cnt <= '0;
            ovf_sticky   <= 1'b0;
        end else begin
            if (wr_ok && wr_word.last && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (drop) begin
                ovf_sticky <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (sync_err && sync_err_cnt != '1) sync_err_cnt <= sync_err_cnt + CNT_W'(1);
        end
    end

`ifdef LVDS_RX_PATTERN_CHK_EN
    logic [7:0] prev_byte;
    logic       seeded;

    // The first byte after reset or a sync loss only seeds the expected sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_byte   <= '0;
            seeded      <= 1'b0;
            pat_err_cnt <= '0;
        end else begin
            if (sync_err) begin
                seeded <= 1'b0;
            end else if (byte_vld) begin
                prev_byte <= byte_q;
                seeded    <= 1'b1;
            end
            if (clr_stats) begin
                pat_err_cnt <= '0;
            end else if (byte_vld && seeded && byte_q != prev_byte + 8'd1 && pat_err_cnt != '1) begin
                pat_err_cnt <= pat_err_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign pat_err_cnt = '0;
`endif

endmodule
